// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder_ctrl                                                          |
// | Bit-serial adder sequencer: two half-adder cells stepped LSB-first, one    |
// | bit per clock, with valid/ready handshakes on operands and result.         |
// | Optional macro: SERIAL_SUB_EN (two's-complement subtract via ~b, cin=1).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;

  logic             w_accept;
  logic             w_last;
  logic             w_s1;
  logic             w_c1;
  logic             w_bit;
  logic             w_c2;
  logic             w_cn;
  logic [WIDTH-1:0] w_sum_nxt;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin;

`ifdef SERIAL_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_cin  = sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_in       = b;
  assign w_cin        = 1'b0;
`endif

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == c_LAST);

  // Two cascaded half adders form the shared 1-bit full adder.
  assign w_s1  = r_op_a[0] ^ r_op_b[0];
  assign w_c1  = r_op_a[0] & r_op_b[0];
  assign w_bit = w_s1 ^ r_c;
  assign w_c2  = w_s1 & r_c;
  assign w_cn  = w_c1 | w_c2;

  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_nxt = w_bit;
    end else begin : g_sum_wn
      assign w_sum_nxt = {w_bit, r_sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_RUN;
      c_RUN:   if (w_last) w_state_nxt = c_DONE;
      c_DONE:  if (out_ready) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_IDLE);
    out_valid = (r_state == c_DONE);
    busy      = (r_state == c_RUN) || (r_state == c_DONE);
  end

  // The carry register doubles as the registered carry-out once RUN ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_op_a <= a;
      r_op_b <= w_b_in;
      r_sum  <= '0;
      r_c    <= w_cin;
    end else if (r_state == c_RUN) begin
      r_cnt  <= r_cnt + c_CW'(1);
      r_op_a <= r_op_a >> 1;
      r_op_b <= r_op_b >> 1;
      r_sum  <= w_sum_nxt;
      r_c    <= w_cn;
    end
  end

  assign sum   = r_sum;
  assign carry = r_c;

endmodule
`default_nettype wire
